alu_request_arbiter: RTL
========================

// Module: alu_request_arbiter
// PURPOSE
//  Shares the single ALU datapath between NUM_REQ requesters (e.g. execute stage,
//  address-gen, debug port). Round-robin arbitration, one op in flight at a time.
//  Registers the winner's operands/control onto the ALU, waits ALU_LATENCY cycles,
//  captures the result, returns it to the winner over a valid/ready response channel.
// PARAMETERS
//  WORD_SIZE    19  operand/result width (matches constants::WORD_SIZE)
//  NUM_REQ      2   number of requesters, >=2
//  OP_W         5   ALU opcode field width
//  ALU_LATENCY  1   cycles from alu_issue to valid alu_result, >=1
// PORTS
//  CLK         in   1                  clock, rising edge
//  RESET       in   1                  asynchronous reset, active-low
//  req_valid   in   NUM_REQ            per-requester op request
//  req_ready   out  NUM_REQ            per-requester accept
//  req_mode    in   NUM_REQ            per-requester MODE (1=logical, 0=arithmetic)
//  req_op      in   NUM_REQ*OP_W       per-requester opcode, requester i at [i*OP_W +: OP_W]
//  req_a       in   NUM_REQ*WORD_SIZE  operand 1, requester i at [i*WORD_SIZE +: WORD_SIZE]
//  req_b       in   NUM_REQ*WORD_SIZE  operand 2, same packing as req_a
//  rsp_valid   out  NUM_REQ            result valid, one-hot to the granted requester
//  rsp_ready   in   NUM_REQ            requester accepts result
//  rsp_result  out  WORD_SIZE          shared result bus
//  alu_mode    out  1                  to ALU MODE
//  alu_op      out  OP_W               to ALU opcode
//  alu_op_a    out  WORD_SIZE          to ALU operand 1
//  alu_op_b    out  WORD_SIZE          to ALU operand 2
//  alu_issue   out  1                  one-cycle pulse: new op on ALU inputs
//  alu_result  in   WORD_SIZE          from ALU
//  busy        out  1                  high in any state except IDLE
// BEHAVIOUR
//  - Reset (RESET=0, async): state=IDLE, rr_ptr=0, cnt=0; all outputs 0.
//    In-flight op dropped, no response generated; applies in any state.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE:
//    - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - req_ready[g]=1 combinationally, all other req_ready=0.
//    - No valid request: no grant, stay IDLE.
//    - On transfer: latch g, mode/op/a/b into the ALU output regs, cnt=0, go EXEC.
//    - Requester may drop req_valid after transfer.
//    - Dropping req_valid before transfer is legal; nothing is committed.
//  - EXEC:
//    - alu_issue=1 in the first EXEC cycle only.
//    - alu_* outputs held stable from EXEC entry until return to IDLE.
//    - cnt increments each cycle.
//    - When cnt==ALU_LATENCY-1: capture alu_result into rsp_result, go RESP.
//    - EXEC lasts exactly ALU_LATENCY cycles.
//  - RESP:
//    - rsp_valid[g]=1; rsp_result held stable.
//    - On rsp_valid[g]&rsp_ready[g]: rr_ptr=(g+1) mod NUM_REQ, go IDLE.
//    - rsp_ready[g] low: wait indefinitely, nothing changes.
//  - req_ready=0 in EXEC/RESP. rsp_ready of non-granted requesters, and all
//    rsp_ready outside RESP, are ignored.
//  - Latency: accept (cycle 0) -> rsp_valid at cycle 1+ALU_LATENCY.
//    Next accept no earlier than one cycle after the response handshake.
//  - Width: operands/result passed unmodified at WORD_SIZE bits; no extension or truncation.
//  - rr_ptr wraps NUM_REQ-1 -> 0. rr_ptr is updated only on a completed response.
// TESTING
//  1. Reset: assert RESET=0 mid-idle -> all outputs 0 same cycle; busy=0, rr_ptr=0.
//  2. Single op, ALU_LATENCY=1: req0 mode=0, a=0x00005, b=0x00003, ALU model returns
//     0x00008 -> alu_issue at cycle 1, rsp_valid[0]=1 and rsp_result=0x00008 at cycle 2.
//  3. Fairness, NUM_REQ=3: all req_valid held high -> grant order 0,1,2,0,1,2.
//     Each requester sees exactly one rsp_valid per round.
//  4. Backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid[0] and
//     rsp_result stable, req_ready=0, busy=1. Release -> IDLE next cycle, rr_ptr=1.
//  5. Reset mid-EXEC, ALU_LATENCY=3: RESET=0 in EXEC cycle 2 -> outputs 0
//     immediately; after release, no rsp_valid and first grant goes to req0.
//  6. Full-width passthrough: a=0x7FFFF, b=0x40000, mode=1 -> alu_op_a/b exact.
//     Model result 0x7FFFF returned unchanged on rsp_result.

Source files
------------

// File: rtl/alu_arb_if.sv
// Bus bundle between the ALU request arbiter, its requesters and the shared ALU.
// The slave modport is the arbiter's view; the master modport is the
// requesters-plus-ALU side that surrounds it.
interface alu_arb_if #(
    parameter int WORD_SIZE = 19,
    parameter int NUM_REQ   = 2,
    parameter int OP_W      = 5
) ();
    // Requester side
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_mode;
    logic [NUM_REQ*OP_W-1:0]      req_op;
    logic [NUM_REQ*WORD_SIZE-1:0] req_a;
    logic [NUM_REQ*WORD_SIZE-1:0] req_b;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_ready;
    logic [WORD_SIZE-1:0]         rsp_result;

    // ALU side
    logic                         alu_mode;
    logic [OP_W-1:0]              alu_op;
    logic [WORD_SIZE-1:0]         alu_op_a;
    logic [WORD_SIZE-1:0]         alu_op_b;
    logic                         alu_issue;
    logic [WORD_SIZE-1:0]         alu_result;

    modport slave (
        input  req_valid, req_mode, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result,
               alu_mode, alu_op, alu_op_a, alu_op_b, alu_issue
    );

    modport master (
        output req_valid, req_mode, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result,
               alu_mode, alu_op, alu_op_a, alu_op_b, alu_issue
    );
endinterface

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// One operation in flight: accept in IDLE, drive the ALU for ALU_LATENCY
// cycles in EXEC, then hold the captured result in RESP until the winner
// takes it. The round-robin pointer only advances on a completed response.
module alu_request_arbiter #(
    parameter int WORD_SIZE   = 19,
    parameter int NUM_REQ     = 2,
    parameter int OP_W        = 5,
    parameter int ALU_LATENCY = 1
) (
    input  logic      CLK,
    input  logic      RESET,
    alu_arb_if.slave  bus,
    output logic      busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     grant_q,  grant_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 mode_q,   mode_d;
    logic [OP_W-1:0]      op_q,     op_d;
    logic [WORD_SIZE-1:0] a_q,      a_d;
    logic [WORD_SIZE-1:0] b_q,      b_d;
    logic [WORD_SIZE-1:0] result_q, result_d;

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   req_ready_vec;
    logic [NUM_REQ-1:0]   rsp_valid_vec;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Next-state and handshake outputs of the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        req_ready_vec = '0;
        rsp_valid_vec = '0;

        case (state_q)
            IDLE: begin
                // Ready is gated by reset so every output reads 0 while held in reset.
                if (grant_found && RESET) begin
                    req_ready_vec[grant_idx] = 1'b1;
                    grant_d  = grant_idx;
                    mode_d   = bus.req_mode[grant_idx];
                    op_d     = bus.req_op[int'(grant_idx)*OP_W +: OP_W];
                    a_d      = bus.req_a[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
                    b_d      = bus.req_b[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
                    cnt_d    = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ALU_LATENCY - 1)) begin
                    result_d = bus.alu_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                rsp_valid_vec[grant_q] = 1'b1;
                if (bus.rsp_ready[grant_q]) begin
                    rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign bus.req_ready[gi] = req_ready_vec[gi];
            assign bus.rsp_valid[gi] = rsp_valid_vec[gi];
        end
    endgenerate

    assign bus.rsp_result = result_q;
    assign bus.alu_mode   = mode_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_op_a   = a_q;
    assign bus.alu_op_b   = b_q;
    assign bus.alu_issue  = (state_q == EXEC) && (cnt_q == '0);
    assign busy           = (state_q != IDLE);
endmodule
